mmio_responder: RTL

//  Memory-mapped I/O responder: the peripheral side of the CPU's IORead/IOWrite strobes (raised for

---
 rtl/mmio_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// mmio_responder: peripheral side of the CPU's I/O strobes. Holds the LED register,
// debounces switches and buttons, and scans an 8-digit seven-segment display.
module mmio_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [9:0]  addr_low,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch_in,
    input  logic [4:0]  button_in,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam logic [9:0] AddrLed     = 10'h060;
    localparam logic [9:0] AddrSwitch  = 10'h070;
    localparam logic [9:0] AddrButton  = 10'h074;
    localparam logic [9:0] AddrSegVal  = 10'h080;
    localparam logic [9:0] AddrSegMask = 10'h084;

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ScanW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);

    // Active-low hex font, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Bus-visible registers
    logic [15:0] led_q, led_d;
    logic [31:0] seg_value_q, seg_value_d;
    logic [7:0]  seg_mask_q, seg_mask_d;

    // Switch input path
    logic [15:0]    sw_meta_q, sw_sync_q, sw_prev_q, sw_deb_q, sw_deb_d;
    logic [DbW-1:0] sw_cnt_q, sw_cnt_d;

    // Button input path
    logic [4:0]     bt_meta_q, bt_sync_q, bt_prev_q, bt_deb_q, bt_deb_d;
    logic [DbW-1:0] bt_cnt_q, bt_cnt_d;

    // Display scan
    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seg_an_q, seg_an_d;
    logic [7:0]       seg_out_q, seg_out_d;

    // Register file write decode; unmapped addresses are ignored.
    always_comb begin
        led_d       = led_q;
        seg_value_d = seg_value_q;
        seg_mask_d  = seg_mask_q;
        if (IOWrite) begin
            case (addr_low)
                AddrLed:     led_d       = wdata[15:0];
                AddrSegVal:  seg_value_d = wdata;
                AddrSegMask: seg_mask_d  = wdata[7:0];
                default:     ;
            endcase
        end
    end

    // Read mux; combinational so a load sees the pre-write value of a same-cycle store.
    always_comb begin
        rdata = 32'h0;
        if (IORead) begin
            case (addr_low)
                AddrLed:     rdata = {16'h0, led_q};
                AddrSwitch:  rdata = {16'h0, sw_deb_q};
                AddrButton:  rdata = {27'h0, bt_deb_q};
                AddrSegVal:  rdata = seg_value_q;
                AddrSegMask: rdata = {24'h0, seg_mask_q};
                default:     rdata = 32'h0;
            endcase
        end
    end

    // Switch debounce. A change of the synchronized value while a count is in progress
    // restarts it; the cycle on which the count begins already counts as stable.
    always_comb begin
        sw_cnt_d = sw_cnt_q;
        sw_deb_d = sw_deb_q;
        if (sw_sync_q == sw_deb_q) begin
            sw_cnt_d = '0;
        end else if ((sw_sync_q != sw_prev_q) && (sw_cnt_q != '0)) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DbMax) begin
            sw_deb_d = sw_sync_q;
            sw_cnt_d = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    // Button debounce, same scheme as the switches.
    always_comb begin
        bt_cnt_d = bt_cnt_q;
        bt_deb_d = bt_deb_q;
        if (bt_sync_q == bt_deb_q) begin
            bt_cnt_d = '0;
        end else if ((bt_sync_q != bt_prev_q) && (bt_cnt_q != '0)) begin
            bt_cnt_d = '0;
        end else if (bt_cnt_q == DbMax) begin
            bt_deb_d = bt_sync_q;
            bt_cnt_d = '0;
        end else begin
            bt_cnt_d = bt_cnt_q + 1'b1;
        end
    end

    // Scan timing and next pin values for the currently selected digit.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == ScanMax) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end
        seg_an_d  = seg_mask_q[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
        seg_out_d = {1'b1, hex7(seg_value_q[{idx_q, 2'b00} +: 4])};
    end

    // Bus registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q       <= 16'h0;
            seg_value_q <= 32'h0;
            seg_mask_q  <= 8'h0;
        end else begin
            led_q       <= led_d;
            seg_value_q <= seg_value_d;
            seg_mask_q  <= seg_mask_d;
        end
    end

    // Switch synchronizer and debounce state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
            sw_prev_q <= 16'h0;
            sw_deb_q  <= 16'h0;
            sw_cnt_q  <= '0;
        end else begin
            sw_meta_q <= switch_in;
            sw_sync_q <= sw_meta_q;
            sw_prev_q <= sw_sync_q;
            sw_deb_q  <= sw_deb_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    // Button synchronizer and debounce state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bt_meta_q <= 5'h0;
            bt_sync_q <= 5'h0;
            bt_prev_q <= 5'h0;
            bt_deb_q  <= 5'h0;
            bt_cnt_q  <= '0;
        end else begin
            bt_meta_q <= button_in;
            bt_sync_q <= bt_meta_q;
            bt_prev_q <= bt_sync_q;
            bt_deb_q  <= bt_deb_d;
            bt_cnt_q  <= bt_cnt_d;
        end
    end

    // Display scan state and registered pins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= 3'd0;
            seg_an_q   <= 8'hFF;
            seg_out_q  <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_an_q   <= seg_an_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign led     = led_q;
    assign seg_an  = seg_an_q;
    assign seg_out = seg_out_q;

endmodule
